// File: rtl/pll_pkg.sv
// ---------------------------------------------------------------------------
// pll_pkg
// Shared definitions for the PLL reset generator: the FSM state encoding and
// the width of the lock-loss event counter.
// No ports (package).
// ---------------------------------------------------------------------------
package pll_pkg;

    // 2'b11 is deliberately left unencoded; the FSM treats it as illegal and
    // steers back to S_WAIT_LOCK.
    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'b00,
        S_STABLE    = 2'b01,
        S_RUN       = 2'b10
    } state_t;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/pll_reset_gen_sync.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-stage flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk_i   - destination clock, rising edge
//   rst_ni  - asynchronous active-low reset, clears every stage to 0
//   d_i     - asynchronous input level
//   q_o     - synchronized output (last stage of the chain)
// Parameter STAGES (2..4) sets the chain depth.
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw input through the chain; only the final stage is trusted
    // to have resolved any metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pll_reset_gen.sv
// ---------------------------------------------------------------------------
// pll_reset_gen
// Holds downstream logic in reset until the PLL lock indication has been
// continuously high for STABLE_CYCLES synchronized cycles, and re-asserts
// reset when lock is lost.
// Ports:
//   clk           - PLL output clock, rising edge
//   rst_n         - asynchronous active-low reset
//   locked        - PLL lock indication, asynchronous to clk
//   rst_out_n     - downstream reset, async assert / sync release
//   ready         - high exactly while the FSM is in S_RUN
//   state         - current FSM state encoding
//   lock_loss_cnt - saturating count of lock losses while running
// Configuration macro: PLL_RESET_GEN_LOSS_CNT_EN
//   defined   - lock_loss_cnt counts RUN-to-lock-loss events, saturating
//   undefined - lock_loss_cnt is tied to zero and no counter flops exist
// ---------------------------------------------------------------------------
module pll_reset_gen
    import pll_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked,
    output logic                  rst_out_n,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    // Smallest counter that can hold STABLE_CYCLES-1, never narrower than 1.
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             lockedSync;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rstOut_q;
    logic             ready_q;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (locked),
        .q_o   (lockedSync)
    );

    // Main FSM. The reset and ready flops are updated on the same edge that
    // enters or leaves S_RUN so neither output has a combinational path from
    // the lock input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_WAIT_LOCK;
            cnt_q    <= '0;
            rstOut_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    cnt_q    <= '0;
                    rstOut_q <= 1'b0;
                    ready_q  <= 1'b0;
                    if (lockedSync) begin
                        state_q <= S_STABLE;
                    end
                end
                S_STABLE: begin
                    // Lock drop is tested first so it wins over terminal count.
                    if (!lockedSync) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == TERM_CNT) begin
                        state_q  <= S_RUN;
                        cnt_q    <= '0;
                        rstOut_q <= 1'b1;
                        ready_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    cnt_q <= '0;
                    if (!lockedSync) begin
                        state_q  <= S_WAIT_LOCK;
                        rstOut_q <= 1'b0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_WAIT_LOCK;
                    cnt_q    <= '0;
                    rstOut_q <= 1'b0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_RESET_GEN_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] lossCnt_q;

    // Counts each exit from S_RUN caused by lock loss, on the same edge the
    // FSM leaves S_RUN, and holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lossCnt_q <= '0;
        end else if ((state_q == S_RUN) && !lockedSync && (lossCnt_q != '1)) begin
            lossCnt_q <= lossCnt_q + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_cnt = lossCnt_q;
`else
    assign lock_loss_cnt = '0;
`endif

    assign rst_out_n = rstOut_q;
    assign ready     = ready_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_gen.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_gen
// Directed self-checking bench for pll_reset_gen with SYNC_STAGES=2 and
// STABLE_CYCLES=16. Inputs change on the falling clock edge and outputs are
// sampled there too, away from the rising edge the design uses.
// Expected lock_loss_cnt values follow PLL_RESET_GEN_LOSS_CNT_EN.
// ---------------------------------------------------------------------------
module tb_pll_reset_gen;

    import pll_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       rst_out_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_cnt;

    int passCount;
    int totalCount;
    logic seenRelease;

    pll_reset_gen #(
        .STABLE_CYCLES(16),
        .SYNC_STAGES  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .rst_out_n    (rst_out_n),
        .ready        (ready),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected loss count after n lock-loss events from S_RUN.
    function automatic logic [7:0] expLoss(input int n);
`ifdef PLL_RESET_GEN_LOSS_CNT_EN
        return (n > 255) ? 8'hFF : n[7:0];
`else
        return 8'h00;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic lockVal, input int edges);
        locked = lockVal;
        waitEdges(edges);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n  = 1'b0;
        locked = 1'b0;
        waitEdges(2);
        rst_n = 1'b1;
        waitEdges(1);
    endtask

    // One lock-loss event from S_RUN followed by full re-qualification.
    task automatic lossEvent();
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 19);
    endtask

    // Directed sequence of steps covering the main behaviours.
    initial begin
        passCount   = 0;
        totalCount  = 0;
        seenRelease = 1'b0;
        rst_n       = 1'b1;
        locked      = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_rst_out_n", {31'b0, rst_out_n}, 32'd0);
        checkOutput("reset_ready", {31'b0, ready}, 32'd0);
        checkOutput("reset_state", {30'b0, state}, 32'd0);
        checkOutput("reset_loss_cnt", {24'b0, lock_loss_cnt}, 32'd0);
        waitEdges(2);
        rst_n = 1'b1;
        waitEdges(2);
        checkOutput("idle_state", {30'b0, state}, 32'd0);

        applyStimulus(1'b1, 18);
        checkOutput("qual_edge18_rst", {31'b0, rst_out_n}, 32'd0);
        checkOutput("qual_edge18_ready", {31'b0, ready}, 32'd0);
        checkOutput("qual_edge18_state", {30'b0, state}, 32'd1);
        waitEdges(1);
        checkOutput("qual_edge19_rst", {31'b0, rst_out_n}, 32'd1);
        checkOutput("qual_edge19_ready", {31'b0, ready}, 32'd1);
        checkOutput("qual_edge19_state", {30'b0, state}, 32'd2);
        checkOutput("qual_loss_cnt", {24'b0, lock_loss_cnt}, 32'd0);

        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        checkOutput("drop_edge2_rst", {31'b0, rst_out_n}, 32'd1);
        waitEdges(1);
        checkOutput("drop_edge3_rst", {31'b0, rst_out_n}, 32'd0);
        checkOutput("drop_edge3_ready", {31'b0, ready}, 32'd0);
        checkOutput("drop_edge3_state", {30'b0, state}, 32'd0);
        checkOutput("drop_loss_cnt", {24'b0, lock_loss_cnt}, {24'b0, expLoss(1)});
        waitEdges(16);
        checkOutput("requal_edge19_rst", {31'b0, rst_out_n}, 32'd0);
        waitEdges(1);
        checkOutput("requal_edge20_rst", {31'b0, rst_out_n}, 32'd1);
        checkOutput("requal_edge20_state", {30'b0, state}, 32'd2);

        for (int i = 2; i <= 300; i++) begin
            lossEvent();
            if (i == 10 || i == 255 || i == 256 || i == 300) begin
                checkOutput($sformatf("loss_cnt_%0d", i), {24'b0, lock_loss_cnt},
                            {24'b0, expLoss(i)});
            end
        end
        checkOutput("after_losses_rst", {31'b0, rst_out_n}, 32'd1);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_n", {31'b0, rst_out_n}, 32'd0);
        checkOutput("async_ready", {31'b0, ready}, 32'd0);
        checkOutput("async_state", {30'b0, state}, 32'd0);
        checkOutput("async_loss_cnt", {24'b0, lock_loss_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        doReset();
        applyStimulus(1'b1, 16);
        applyStimulus(1'b0, 2);
        checkOutput("tie_edge18_state", {30'b0, state}, 32'd1);
        waitEdges(1);
        checkOutput("tie_edge19_state", {30'b0, state}, 32'd0);
        checkOutput("tie_edge19_rst", {31'b0, rst_out_n}, 32'd0);
        checkOutput("tie_edge19_ready", {31'b0, ready}, 32'd0);

        doReset();
        applyStimulus(1'b1, 10);
        locked = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rst_out_n !== 1'b0 || ready !== 1'b0) seenRelease = 1'b1;
        end
        checkOutput("pulse_no_release", {31'b0, seenRelease}, 32'd0);
        checkOutput("pulse_state", {30'b0, state}, 32'd0);
        checkOutput("pulse_loss_cnt", {24'b0, lock_loss_cnt}, 32'd0);

        doReset();
        applyStimulus(1'b1, 19);
        checkOutput("force_pre_state", {30'b0, state}, 32'd2);
        force dut.state_q = state_t'(2'b11);
        #1 release dut.state_q;
        checkOutput("force_illegal_state", {30'b0, state}, 32'd3);
        waitEdges(1);
        checkOutput("force_recover_state", {30'b0, state}, 32'd0);
        checkOutput("force_recover_rst", {31'b0, rst_out_n}, 32'd0);
        checkOutput("force_recover_ready", {31'b0, ready}, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/pll_reset_gen.md
PLL_RESET_GEN -- requirements
Module: pll_reset_gen

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: cycles of continuous synchronized lock required before reset release; legal range 1..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: depth of the lock-input synchronizer; legal range 2..4.
REQ-003 SHALL have port clk  input  1: single clock, the PLL output clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port locked  input  1: PLL lock indication, treated as asynchronous to clk.
REQ-006 SHALL have port rst_out_n  output  1: active-low reset for downstream logic; assert asynchronous, release synchronous.
REQ-007 SHALL have port ready  output  1: high when and only when the FSM is in S_RUN.
REQ-008 SHALL have port state  output  2: current FSM state encoding.
REQ-009 SHALL have port lock_loss_cnt  output  8: count of RUN-to-lock-loss events, saturating.

Function
REQ-010 SHALL pass locked through a SYNC_STAGES-deep flop chain; only the last stage (locked_s) is used by the FSM.
REQ-011 SHALL implement FSM states S_WAIT_LOCK=2'b00, S_STABLE=2'b01, S_RUN=2'b10; 2'b11 unused and SHALL recover to S_WAIT_LOCK on the next edge.
REQ-012 In S_WAIT_LOCK: stable counter held at 0; locked_s=1 -> S_STABLE.
REQ-013 In S_STABLE: counter increments by 1 per cycle; locked_s=0 -> S_WAIT_LOCK with counter cleared; counter==STABLE_CYCLES-1 with locked_s=1 -> S_RUN.
REQ-014 In S_RUN: locked_s=0 -> S_WAIT_LOCK and lock_loss_cnt increments by 1 on the same edge.
REQ-015 Simultaneous lock drop and terminal count in S_STABLE SHALL resolve to S_WAIT_LOCK (lock drop wins).
REQ-016 lock_loss_cnt SHALL saturate at 8'hFF; no wrap.
REQ-017 rst_out_n and ready SHALL be driven from dedicated flops, set on the edge entering S_RUN and cleared on the edge leaving it; no combinational path from locked to any output.
REQ-018 From the first edge sampling locked=1 (held high), rst_out_n SHALL rise on edge SYNC_STAGES+STABLE_CYCLES+1.
REQ-019 Lock-drop latency: rst_out_n SHALL fall on edge SYNC_STAGES+1 after the first edge sampling locked=0.
REQ-020 Stable counter width SHALL be the minimum needed to hold STABLE_CYCLES-1, and at least 1 bit.

Reset
REQ-021 rst_n=0 SHALL asynchronously force: synchronizer flops 0, state S_WAIT_LOCK, counter 0, rst_out_n 0, ready 0, lock_loss_cnt 0.
REQ-022 rst_n deassertion SHALL be taken as synchronous to clk; the FSM starts from S_WAIT_LOCK on the first edge after release.
REQ-023 rst_n asserted mid-S_STABLE or mid-S_RUN SHALL abort immediately, with no increment of lock_loss_cnt.

Configuration
REQ-024 Macro PLL_RESET_GEN_LOSS_CNT_EN defined: lock_loss_cnt is implemented per REQ-014/REQ-016.
REQ-025 Macro PLL_RESET_GEN_LOSS_CNT_EN undefined: lock_loss_cnt is tied to 8'h00 with no counter flops; all other behaviour is unchanged.

Structure
REQ-026 Shared package pll_pkg SHALL hold the state typedef (S_WAIT_LOCK/S_STABLE/S_RUN) and constant LOSS_CNT_W=8.
REQ-027 The synchronizer SHALL be the sub-module sync_ff (parameter STAGES, async active-low reset to 0); the FSM and counters stay in pll_reset_gen.

Verification
REQ-028 SYNC_STAGES=2, STABLE_CYCLES=16, locked held 1 from edge 0 -> rst_out_n and ready rise on edge 19; state=2'b10.
REQ-029 Same config; locked pulses high for 10 cycles, then low -> never reaches S_RUN, rst_out_n stays 0, lock_loss_cnt=0.
REQ-030 In S_RUN, locked drops for 1 cycle -> rst_out_n falls 3 edges later, lock_loss_cnt=1, full 19-edge re-qualification before release.
REQ-031 300 lock-loss events from S_RUN -> lock_loss_cnt=8'hFF (without macro: 8'h00 throughout).
REQ-032 rst_n pulsed low between clock edges while in S_RUN -> rst_out_n=0 with no clock edge, all state cleared, lock_loss_cnt=0.
REQ-033 Force state 2'b11 -> S_WAIT_LOCK on the next edge, with rst_out_n=0.
